// File: rtl/sync_fifo_buf_if.sv
// Handshake/status bundle for sync_fifo_buf. The overflow/underflow wires exist
// only when SYNC_FIFO_ERRFLAG_EN is defined.
interface sync_fifo_buf_if #(
  parameter int li = 4,
  parameter int oi = 32
);
  logic [oi-1:0] data;
  logic          wren;
  logic          rden;
  logic [oi-1:0] q;
  logic          qvalid;
  logic          full;
  logic          empty;
  logic          almostfull;
  logic          almostempty;
  logic [li:0]   level;
`ifdef SYNC_FIFO_ERRFLAG_EN
  logic          overflow;
  logic          underflow;
`endif

  modport master (
    output data, wren, rden,
    input  q, qvalid, full, empty, almostfull, almostempty, level
`ifdef SYNC_FIFO_ERRFLAG_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  data, wren, rden,
    output q, qvalid, full, empty, almostfull, almostempty, level
`ifdef SYNC_FIFO_ERRFLAG_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO with registered read data and registered status flags.
// Optional sticky overflow/underflow flags are enabled by SYNC_FIFO_ERRFLAG_EN.
module sync_fifo_buf #(
  parameter int li   = 4,
  parameter int oi   = 32,
  parameter int afth = 2**li - 2,
  parameter int aeth = 2
) (
  input  logic            clock,
  input  logic            reset,
  sync_fifo_buf_if.slave  bus
);
  localparam logic [li:0] DEPTH = (li+1)'(2**li);

  logic [oi-1:0] mem_q [2**li];

  logic [li-1:0] wr_ptr_q, wr_ptr_d;
  logic [li-1:0] rd_ptr_q, rd_ptr_d;
  logic [li:0]   level_q, level_d;
  logic [oi-1:0] q_q, q_d;
  logic          qvalid_q, qvalid_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          wr_acc, rd_acc;

  // When full, a simultaneous read frees the slot the write lands in; the read
  // data is taken from the old contents before the write commits.
  always_comb begin
    rd_acc   = bus.rden && !empty_q;
    wr_acc   = bus.wren && (!full_q || rd_acc);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    q_d      = q_q;
    qvalid_d = rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + li'(1);
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + li'(1);
      q_d      = mem_q[rd_ptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + (li+1)'(1);
      2'b01:   level_d = level_q - (li+1)'(1);
      default: level_d = level_q;
    endcase
    full_d   = (level_d == DEPTH);
    empty_d  = (level_d == '0);
    afull_d  = (int'(level_d) >= afth);
    aempty_d = (int'(level_d) <= aeth);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      q_q      <= '0;
      qvalid_q <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      q_q      <= q_d;
      qvalid_q <= qvalid_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  // Storage array carries no reset so it maps onto RAM.
  always_ff @(posedge clock) begin
    if (wr_acc && !reset) mem_q[wr_ptr_q] <= bus.data;
  end

  assign bus.q           = q_q;
  assign bus.qvalid      = qvalid_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.almostfull  = afull_q;
  assign bus.almostempty = aempty_q;
  assign bus.level       = level_q;

`ifdef SYNC_FIFO_ERRFLAG_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  || (bus.wren && !wr_acc);
    underflow_d = underflow_q || (bus.rden && !rd_acc);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_sync_fifo_buf.sv
// Scoreboard bench for sync_fifo_buf at li=2, oi=8 using directed vectors.
// Expected read data is queued at issue time and popped by a separate monitor.
module tb_sync_fifo_buf;
  localparam int LI = 2;
  localparam int OI = 8;

  logic clock;
  logic reset;
  sync_fifo_buf_if #(.li(LI), .oi(OI)) bus ();

  sync_fifo_buf #(.li(LI), .oi(OI)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [OI-1:0] exp_q[$];
  logic [OI-1:0] model_mem[$];
  logic [OI-1:0] model_q;
  logic          model_ovf;
  logic          model_unf;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Every cycle with a valid word must match the oldest outstanding read.
  always @(negedge clock) begin
    if (bus.qvalid === 1'b1) begin
      if (exp_q.size() == 0) checkOutput("unexpected_qvalid", 32'd1, 32'd0);
      else checkOutput("scoreboard_q", 32'(bus.q), 32'(exp_q.pop_front()));
    end
  end

  task automatic applyStimulus(input logic wr, input logic rd,
                               input logic [OI-1:0] din, input logic rst);
    logic rd_acc;
    logic wr_acc;
    int   lvl;
    @(negedge clock);
    reset    = rst;
    bus.wren = wr;
    bus.rden = rd;
    bus.data = din;
    lvl    = model_mem.size();
    rd_acc = !rst && rd && (lvl != 0);
    wr_acc = !rst && wr && ((lvl != 4) || rd_acc);
    if (rst) begin
      model_mem.delete();
      model_q   = '0;
      model_ovf = 1'b0;
      model_unf = 1'b0;
    end else begin
      if (wr && !wr_acc) model_ovf = 1'b1;
      if (rd && !rd_acc) model_unf = 1'b1;
      if (rd_acc) begin
        model_q = model_mem.pop_front();
        exp_q.push_back(model_q);
      end
      if (wr_acc) model_mem.push_back(din);
    end
    @(posedge clock);
    #1;
    lvl = model_mem.size();
    checkOutput("level",       32'(bus.level),       32'(lvl));
    checkOutput("full",        32'(bus.full),        32'(lvl == 4));
    checkOutput("empty",       32'(bus.empty),       32'(lvl == 0));
    checkOutput("almostfull",  32'(bus.almostfull),  32'(lvl >= 2));
    checkOutput("almostempty", 32'(bus.almostempty), 32'(lvl <= 2));
    checkOutput("qvalid",      32'(bus.qvalid),      32'(rd_acc));
    checkOutput("q_hold",      32'(bus.q),           32'(model_q));
`ifdef SYNC_FIFO_ERRFLAG_EN
    checkOutput("overflow",    32'(bus.overflow),    32'(model_ovf));
    checkOutput("underflow",   32'(bus.underflow),   32'(model_unf));
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    bus.wren  = 1'b0;
    bus.rden  = 1'b0;
    bus.data  = '0;
    model_q   = '0;
    model_ovf = 1'b0;
    model_unf = 1'b0;

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("reset_q", 32'(bus.q), 32'h0);
    checkOutput("reset_empty", 32'(bus.empty), 32'd1);

    // Fill to full, then a dropped fifth write.
    applyStimulus(1'b1, 1'b0, 8'h11, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h22, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h33, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h44, 1'b0);
    checkOutput("full_after_4", 32'(bus.full), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h55, 1'b0);
    checkOutput("level_after_drop", 32'(bus.level), 32'd4);

    // Drain in order.
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("read1", 32'(bus.q), 32'h11);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("read2", 32'(bus.q), 32'h22);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("read3", 32'(bus.q), 32'h33);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("read4", 32'(bus.q), 32'h44);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("drained_empty", 32'(bus.empty), 32'd1);

    // Simultaneous write+read on empty accepts only the write.
    applyStimulus(1'b1, 1'b1, 8'hA5, 1'b0);
    checkOutput("empty_both_qvalid", 32'(bus.qvalid), 32'd0);
    checkOutput("empty_both_level", 32'(bus.level), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("read_a5", 32'(bus.q), 32'hA5);

    // Full with simultaneous write+read returns oldest; wrap carries 0x66 through.
    applyStimulus(1'b1, 1'b0, 8'h11, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h22, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h33, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h44, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h66, 1'b0);
    checkOutput("full_both_q", 32'(bus.q), 32'h11);
    checkOutput("full_both_level", 32'(bus.level), 32'd4);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("wrap_last_q", 32'(bus.q), 32'h66);

    // Reset with a pending write discards everything.
    applyStimulus(1'b1, 1'b0, 8'h01, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h02, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h03, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h04, 1'b1);
    checkOutput("rst_mid_level", 32'(bus.level), 32'd0);
    checkOutput("rst_mid_q", 32'(bus.q), 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h77, 1'b0);
    checkOutput("first_after_rst", 32'(bus.level), 32'd1);

    // Underflow is sticky across valid traffic.
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h88, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("read_88", 32'(bus.q), 32'h88);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule

// File: doc/sync_fifo_buf.md
SYNC_FIFO_BUF -- requirements
Module: sync_fifo_buf

Interface
REQ-001 SHALL have parameter li, 4, address width; depth = 2**li words.
REQ-002 SHALL have parameter oi, 32, data width in bits.
REQ-003 SHALL have parameter afth, 2**li-2, almost-full threshold (level >= afth asserts almostfull); legal range 1..2**li.
REQ-004 SHALL have parameter aeth, 2, almost-empty threshold (level <= aeth asserts almostempty); legal range 0..2**li-1.
REQ-005 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port data  input  oi  write data.
REQ-008 SHALL have port wren  input  1  write request.
REQ-009 SHALL have port rden  input  1  read request.
REQ-010 SHALL have port q  output  oi  registered read data.
REQ-011 SHALL have port qvalid  output  1  q holds a newly read word this cycle.
REQ-012 SHALL have port full, empty, almostfull, almostempty  output  1 each  registered status flags.
REQ-013 SHALL have port level  output  li+1  current stored word count, 0..2**li.
REQ-014 SHALL have port overflow, underflow  output  1 each  sticky error flags (present only per REQ-031).

Function
REQ-015 Write SHALL be accepted when wren=1 and (full=0 or read accepted in the same cycle); accepted word stored at write pointer, pointer +1.
REQ-016 Read SHALL be accepted when rden=1 and empty=0; read pointer +1.
REQ-017 Read latency SHALL be 1 cycle: q and qvalid=1 in the cycle after acceptance; qvalid=0 otherwise; q holds last value when no read.
REQ-018 Pointers SHALL be li bits, wrapping 2**li-1 -> 0 with no gap.
REQ-019 level SHALL update on the same edge: +1 write only, -1 read only, unchanged for both or neither.
REQ-020 full SHALL equal (level==2**li), empty SHALL equal (level==0), both reflecting post-edge level.
REQ-021 almostfull and almostempty SHALL be derived from post-edge level per REQ-003/004.
REQ-022 Write while full with no read SHALL be dropped; memory, pointers, level unchanged.
REQ-023 Read while empty SHALL be ignored; qvalid stays 0, q unchanged.
REQ-024 Simultaneous write and read while empty SHALL accept the write only; level becomes 1.
REQ-025 Simultaneous write and read while full SHALL accept both; level stays 2**li; the read returns the oldest word, never the new one.
REQ-026 Memory SHALL be inferred as RAM (no reset on storage array).

Reset
REQ-027 reset=1 at a rising edge SHALL force pointers=0, level=0, empty=1, full=0, almostempty=1, almostfull=0, qvalid=0, q=0, overflow=0, underflow=0.
REQ-028 reset SHALL take priority over wren/rden in the same cycle; requests that cycle are discarded.
REQ-029 Reset mid-operation SHALL discard all stored words; memory contents need not clear.
REQ-030 First accepted operation SHALL be possible in the cycle after reset deasserts.

Configuration
REQ-031 With macro SYNC_FIFO_ERRFLAG_EN defined: overflow SHALL set on a dropped write (REQ-022), underflow on an ignored read (REQ-023), both sticky until reset.
REQ-032 Without SYNC_FIFO_ERRFLAG_EN: overflow and underflow ports SHALL be absent and no error logic synthesised; all other behaviour identical.

Verification
REQ-033 li=2,oi=8: reset, write 0x11,0x22,0x33,0x44 -> full=1, level=4, almostfull=1; 5th write 0x55 dropped (overflow=1 with macro).
REQ-034 From full, read 4 -> q=0x11,0x22,0x33,0x44 each one cycle after rden, qvalid pulses; then empty=1, level=0.
REQ-035 Empty, wren+rden same cycle with 0xA5 -> level=1, qvalid=0 next cycle; read next -> q=0xA5.
REQ-036 Full, wren(0x66)+rden same cycle -> level=4, q=oldest word; after 4 further reads last q=0x66 (pointer wrap verified).
REQ-037 Level=3, assert reset with wren=1 -> next cycle level=0, empty=1, q=0, qvalid=0, error flags 0.
REQ-038 Read on empty with macro -> underflow=1, stays 1 through subsequent valid traffic until reset.
